// File: rtl/bin_a_bcd_seq_pkg.sv
// Shared constants for the sequential binary-to-BCD converter: FSM state
// encodings and the double-dabble digit adjust threshold/offset.
package bin_a_bcd_seq_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAdj   = 2'd1,
        StShift = 2'd2,
        StFin   = 2'd3
    } state_t;

    // A digit at or above this value would overflow past 9 when doubled.
    localparam logic [3:0] BCD_LIM = 4'd5;
    localparam logic [3:0] BCD_ADJ = 4'd3;

endpackage

// File: rtl/bin_a_bcd_seq_dig_adj.sv
// Combinational double-dabble cell for one BCD digit: add 3 when the digit is
// 5 or more, wrapping mod 16 with no carry into the next digit.
module bin_a_bcd_seq_dig_adj
    import bin_a_bcd_seq_pkg::*;
(
    input  logic [3:0] i_dig,
    output logic [3:0] o_dig
);

    assign o_dig = (i_dig >= BCD_LIM) ? (i_dig + BCD_ADJ) : i_dig;

endmodule

// File: rtl/bin_a_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3). Alternates ADJ and SHIFT
// phases W_BIN times, then publishes the packed digits with a one-cycle done
// pulse. Uses the same init/busy/done handshake as the upstream multiplier.
module bin_a_bcd_seq
    import bin_a_bcd_seq_pkg::*;
#(
    parameter int unsigned W_BIN = 6,
    parameter int unsigned N_DIG = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [W_BIN-1:0]     bin,
    output logic [4*N_DIG-1:0]   bcd,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CntW = $clog2(W_BIN + 1);
    localparam int unsigned BcdW = 4 * N_DIG;

    state_t              r_state;
    state_t              w_state_d;
    logic [CntW-1:0]     r_cnt;
    logic [CntW-1:0]     w_cnt_dec;
    logic                w_last;
    logic [W_BIN-1:0]    r_work_bin;
    logic [BcdW-1:0]     r_work_bcd;
    logic [BcdW-1:0]     w_adj;
    logic [BcdW-1:0]     w_bcd_shift;
    logic [W_BIN-1:0]    w_bin_shift;
    logic [BcdW-1:0]     r_bcd;
    logic                r_busy;
    logic                r_done;

    assign w_cnt_dec   = r_cnt - CntW'(1);
    assign w_last      = (w_cnt_dec == '0);
    // Top bit of the BCD field falls off; it is zero whenever 10**N_DIG > 2**W_BIN-1.
    assign w_bcd_shift = {r_work_bcd[BcdW-2:0], r_work_bin[W_BIN-1]};
    assign w_bin_shift = {r_work_bin[W_BIN-2:0], 1'b0};

    for (genvar g = 0; g < N_DIG; g++) begin : g_dig
        bin_a_bcd_seq_dig_adj u_adj (
            .i_dig (r_work_bcd[4*g +: 4]),
            .o_dig (w_adj[4*g +: 4])
        );
    end

    // Next-state decode for the conversion sequencer.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (init) w_state_d = StAdj;
            StAdj:   w_state_d = StShift;
            StShift: w_state_d = w_last ? StFin : StAdj;
            StFin:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // State register and remaining-shift counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StIdle && init) begin
                r_cnt <= CntW'(W_BIN);
            end else if (r_state == StShift) begin
                r_cnt <= w_cnt_dec;
            end
        end
    end

    // Datapath: work registers, published result and handshake flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_work_bin <= '0;
            r_work_bcd <= '0;
            r_bcd      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (init) begin
                        r_work_bin <= bin;
                        r_work_bcd <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                StAdj: begin
                    r_work_bcd <= w_adj;
                end
                StShift: begin
                    r_work_bcd <= w_bcd_shift;
                    r_work_bin <= w_bin_shift;
                    if (w_last) begin
                        r_bcd  <= w_bcd_shift;
                        r_done <= 1'b1;
                    end
                end
                StFin: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bcd  = r_bcd;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_bin_a_bcd_seq.sv
// Self-checking bench for bin_a_bcd_seq: directed vector table, full sweep,
// random values, and hand-written sequences for the handshake corner cases.
module tb_bin_a_bcd_seq;

    localparam int unsigned W_BIN = 6;
    localparam int unsigned N_DIG = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [5:0] bin;
    logic [7:0] bcd;
    logic       busy;
    logic       done;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] last_bcd;

    typedef struct {
        logic [5:0] bin;
        logic [7:0] exp;
    } vec_t;

    bin_a_bcd_seq #(
        .W_BIN (W_BIN),
        .N_DIG (N_DIG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .init  (init),
        .bin   (bin),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits of the value by plain arithmetic.
    function automatic logic [7:0] ref_bcd(input int unsigned v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    // Inputs change and outputs are inspected at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One conversion from IDLE; bin is scrambled after the accepting edge.
    task automatic run_conv(input string name, input logic [5:0] v, input logic [7:0] exp);
        int early = 0;
        int stale = 0;
        int not_busy = 0;
        init = 1'b1;
        bin  = v;
        tick();
        init = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            bin = 6'($urandom);
            tick();
            if (j < 12) begin
                if (done !== 1'b0) early++;
                if (bcd !== last_bcd) stale++;
            end
            if (busy !== 1'b1) not_busy++;
        end
        check({name, " done@k+12"}, 32'(done), 32'd1);
        check({name, " bcd"}, 32'(bcd), 32'(exp));
        check({name, " early_done"}, early, 0);
        check({name, " bcd_held"}, stale, 0);
        check({name, " busy_gap"}, not_busy, 0);
        last_bcd = exp;
        tick();
        check({name, " done_cleared"}, 32'(done), 32'd0);
        check({name, " busy_cleared"}, 32'(busy), 32'd0);
        check({name, " bcd_kept"}, 32'(bcd), 32'(exp));
    endtask

    initial begin
        vec_t vecs[5];
        int   dones;
        int   bad;

        vecs[0] = '{bin: 6'd0,  exp: 8'h00};
        vecs[1] = '{bin: 6'd63, exp: 8'h63};
        vecs[2] = '{bin: 6'd49, exp: 8'h49};
        vecs[3] = '{bin: 6'd10, exp: 8'h10};
        vecs[4] = '{bin: 6'd9,  exp: 8'h09};

        reset = 1'b1;
        init  = 1'b0;
        bin   = '0;
        @(negedge clk);
        tick();
        tick();
        check("reset bcd", 32'(bcd), 32'h00);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        reset    = 1'b0;
        last_bcd = 8'h00;
        tick();

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].bin, vecs[i].exp);
        end

        // Exhaustive sweep against the arithmetic model.
        for (int v = 0; v < 64; v++) begin
            run_conv($sformatf("sweep%0d", v), 6'(v), ref_bcd(v));
        end

        // Random values.
        for (int i = 0; i < 20; i++) begin
            int unsigned r;
            r = $urandom_range(63, 0);
            run_conv($sformatf("rand%0d", r), 6'(r), ref_bcd(r));
        end

        // init while busy is ignored.
        init = 1'b1;
        bin  = 6'd37;
        tick();
        for (int j = 1; j <= 12; j++) begin
            init = (j == 4);
            bin  = (j == 4) ? 6'd12 : 6'($urandom);
            tick();
        end
        init = 1'b0;
        check("busy_init done", 32'(done), 32'd1);
        check("busy_init bcd", 32'(bcd), 32'h37);
        tick();
        check("busy_init idle", 32'(busy), 32'd0);
        dones = 0;
        for (int j = 0; j < 16; j++) begin
            tick();
            if (done !== 1'b0) dones++;
        end
        check("busy_init no_second", dones, 0);
        last_bcd = 8'h37;

        // Reset mid-conversion aborts with no done.
        init = 1'b1;
        bin  = 6'd58;
        tick();
        init = 1'b0;
        for (int j = 1; j <= 4; j++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort bcd", 32'(bcd), 32'h00);
        dones = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (done !== 1'b0) dones++;
        end
        check("abort no_done", dones, 0);
        last_bcd = 8'h00;
        run_conv("after_abort", 6'd21, 8'h21);

        // init held high: back-to-back conversions every 14 cycles.
        init = 1'b1;
        bin  = 6'd42;
        tick();
        bad = 0;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (done !== ((j == 12) || (j == 26) || (j == 40))) begin
                bad++;
                $display("FAIL held_init done j=%0d: got %0b", j, done);
            end
            if (done === 1'b1) check($sformatf("held_init bcd j=%0d", j), 32'(bcd), 32'h42);
        end
        check("held_init pulse_pattern", bad, 0);
        init = 1'b0;
        tick();
        tick();
        check("held_init idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
